// File: rtl/lane_phase_scheduler.sv
// lane_phase_scheduler: day-mode phase sequencer for the 8-lane intersection.
// Runs GREEN -> YELLOW -> ALL_RED with its own timers, inserts pedestrian WALK
// phases and preempts for emergency vehicles.
// Optional starvation guard: define SCHED_STARVE_GUARD_EN to add per-lane skip
// counters that force service of a lane skipped STARVE_LIMIT times.
module lane_phase_scheduler #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MIN_GREEN    = 5,
  parameter int unsigned MAX_GREEN    = 30,
  parameter int unsigned YELLOW_T     = 3,
  parameter int unsigned ALLRED_T     = 1,
  parameter int unsigned WALK_T       = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*CNT_W-1:0] lane_counts,
  input  logic               ped_req,
  input  logic               emg_req,
  input  logic [2:0]         emg_lane,
  output logic [7:0]         green,
  output logic [7:0]         yellow,
  output logic               walk,
  output logic [1:0]         phase,
  output logic [2:0]         active_lane
);

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_WALK    = 2'd3
  } phase_e;

  localparam int unsigned TMAX_YA = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
  localparam int unsigned TMAX    = (WALK_T > TMAX_YA) ? WALK_T : TMAX_YA;
  localparam int unsigned TW      = $clog2(TMAX + 1);
  localparam int unsigned EW      = $clog2(MAX_GREEN + 1);

  phase_e           phase_q, phase_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [EW-1:0]    elapsed_q, elapsed_d;
  logic [2:0]       active_q, active_d;
  logic             ped_q, ped_d;
  logic             emg_q, emg_d;
  logic [7:0]       green_q, green_d;
  logic [7:0]       yellow_q, yellow_d;
  logic             walk_q, walk_d;

  logic [CNT_W-1:0] cnt [8];
  logic [2:0]       sel_lane;
  logic             any_cnt;
  logic             green_exit;

`ifdef SCHED_STARVE_GUARD_EN
  logic [3:0]       skip_q [8];
  logic [3:0]       skip_d [8];
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
`endif

  // Unpack the per-lane queue counts.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      cnt[i] = lane_counts[i*CNT_W +: CNT_W];
    end
  end

  // Lane selection: largest count wins, ties go to the first lane in
  // round-robin order starting after the active lane.
  always_comb begin
    logic [2:0]       idx;
    logic [CNT_W-1:0] best;
`ifdef SCHED_STARVE_GUARD_EN
    logic             starved;
`endif
    sel_lane = active_q;
    best     = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = active_q + 3'(k);
      if (cnt[idx] > best) begin
        best     = cnt[idx];
        sel_lane = idx;
      end
    end
    any_cnt = (best != '0);
`ifdef SCHED_STARVE_GUARD_EN
    // A starved lane with traffic overrides the max-count choice.
    starved = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = active_q + 3'(k);
      if (!starved && (cnt[idx] != '0) && (skip_q[idx] >= 4'(STARVE_LIMIT))) begin
        starved  = 1'b1;
        sel_lane = idx;
      end
    end
`endif
  end

  // Green exit decision for the current cycle.
  always_comb begin
    green_exit = 1'b0;
    if (emg_req && (emg_lane != active_q)) begin
      green_exit = 1'b1;
    end else if (emg_req) begin
      green_exit = 1'b0;
    end else if (emg_q) begin
      green_exit = (elapsed_q >= EW'(MIN_GREEN));
    end else begin
      green_exit = ((elapsed_q >= EW'(MIN_GREEN)) && (cnt[active_q] == '0)) ||
                   (elapsed_q >= EW'(MAX_GREEN));
    end
  end

  // Next-state logic for the phase sequencer and registered outputs.
  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q;
    elapsed_d = elapsed_q;
    active_d  = active_q;
    ped_d     = ped_q | ped_req;
    emg_d     = emg_q;
`ifdef SCHED_STARVE_GUARD_EN
    skip_d    = skip_q;
`endif

    unique case (phase_q)
      PH_ALL_RED: begin
        if (timer_q > TW'(1)) begin
          timer_d = timer_q - TW'(1);
        end else if (emg_req) begin
          phase_d   = PH_GREEN;
          active_d  = emg_lane;
          elapsed_d = EW'(1);
          emg_d     = 1'b1;
`ifdef SCHED_STARVE_GUARD_EN
          skip_d[emg_lane] = '0;
`endif
        end else if (ped_q) begin
          phase_d = PH_WALK;
          timer_d = TW'(WALK_T);
          ped_d   = 1'b0;
        end else if (any_cnt) begin
          phase_d   = PH_GREEN;
          active_d  = sel_lane;
          elapsed_d = EW'(1);
`ifdef SCHED_STARVE_GUARD_EN
          for (int unsigned i = 0; i < 8; i++) begin
            if (3'(i) == sel_lane) begin
              skip_d[i] = '0;
            end else if ((cnt[i] != '0) && (skip_q[i] != 4'hF)) begin
              skip_d[i] = skip_q[i] + 4'd1;
            end
          end
`endif
        end
      end
      PH_GREEN: begin
        if (green_exit) begin
          phase_d = PH_YELLOW;
          timer_d = TW'(YELLOW_T);
          emg_d   = 1'b0;
        end else begin
          // Saturates at MAX_GREEN; emergency hold only needs >= MIN_GREEN.
          if (elapsed_q < EW'(MAX_GREEN)) elapsed_d = elapsed_q + EW'(1);
          if (emg_req) emg_d = 1'b1;
        end
      end
      PH_YELLOW: begin
        if (timer_q > TW'(1)) begin
          timer_d = timer_q - TW'(1);
        end else begin
          phase_d = PH_ALL_RED;
          timer_d = TW'(ALLRED_T);
        end
      end
      PH_WALK: begin
        if (emg_req || (timer_q <= TW'(1))) begin
          phase_d = PH_ALL_RED;
          timer_d = TW'(ALLRED_T);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase

    green_d  = (phase_d == PH_GREEN)  ? (8'd1 << active_d) : '0;
    yellow_d = (phase_d == PH_YELLOW) ? (8'd1 << active_d) : '0;
    walk_d   = (phase_d == PH_WALK);
  end

  // State and output registers with synchronous reset to ALL_RED.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_ALL_RED;
      timer_q   <= TW'(ALLRED_T);
      elapsed_q <= '0;
      active_q  <= 3'd7;
      ped_q     <= 1'b0;
      emg_q     <= 1'b0;
      green_q   <= '0;
      yellow_q  <= '0;
      walk_q    <= 1'b0;
`ifdef SCHED_STARVE_GUARD_EN
      for (int unsigned i = 0; i < 8; i++) skip_q[i] <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      elapsed_q <= elapsed_d;
      active_q  <= active_d;
      ped_q     <= ped_d;
      emg_q     <= emg_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      walk_q    <= walk_d;
`ifdef SCHED_STARVE_GUARD_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign green       = green_q;
  assign yellow      = yellow_q;
  assign walk        = walk_q;
  assign phase       = phase_q;
  assign active_lane = active_q;

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Self-checking bench for lane_phase_scheduler: directed vector table, a few
// hand-written corner sequences, and random stimulus against a reference model.
module tb_lane_phase_scheduler;

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned MIN_GREEN    = 5;
  localparam int unsigned MAX_GREEN    = 30;
  localparam int unsigned YELLOW_T     = 3;
  localparam int unsigned ALLRED_T     = 1;
  localparam int unsigned WALK_T       = 10;
  localparam int unsigned STARVE_LIMIT = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [8*CNT_W-1:0] lane_counts;
  logic               ped_req;
  logic               emg_req;
  logic [2:0]         emg_lane;
  logic [7:0]         green;
  logic [7:0]         yellow;
  logic               walk;
  logic [1:0]         phase;
  logic [2:0]         active_lane;

  int n_cmp  = 0;
  int n_fail = 0;

  lane_phase_scheduler #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .lane_counts(lane_counts), .ped_req(ped_req),
    .emg_req(emg_req), .emg_lane(emg_lane), .green(green), .yellow(yellow),
    .walk(walk), .phase(phase), .active_lane(active_lane)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (phase 0=ALL_RED 1=GREEN 2=YELLOW 3=WALK)
  int m_phase, m_left, m_elapsed, m_active;
  bit m_ped, m_emg;
  int m_skip [8];

  function automatic int lane_cnt(input int l);
    return int'(lane_counts[l*CNT_W +: CNT_W]);
  endfunction

  function automatic int model_pick();
    int maxc, best, bestd, d;
    bit starved_any, cand;
    maxc = 0; best = -1; bestd = 8; starved_any = 0;
    for (int l = 0; l < 8; l++) if (lane_cnt(l) > maxc) maxc = lane_cnt(l);
`ifdef SCHED_STARVE_GUARD_EN
    for (int l = 0; l < 8; l++)
      if (lane_cnt(l) > 0 && m_skip[l] >= int'(STARVE_LIMIT)) starved_any = 1;
`endif
    for (int l = 0; l < 8; l++) begin
      cand = (lane_cnt(l) > 0) && (lane_cnt(l) == maxc);
      if (starved_any) cand = (lane_cnt(l) > 0) && (m_skip[l] >= int'(STARVE_LIMIT));
      d = (l - m_active - 1 + 16) % 8;
      if (cand && d < bestd) begin bestd = d; best = l; end
    end
    return best;
  endfunction

  task automatic model_step();
    bit new_ped, leave;
    int pick;
    if (rst) begin
      m_phase = 0; m_left = ALLRED_T; m_elapsed = 0; m_active = 7;
      m_ped = 0; m_emg = 0;
      for (int l = 0; l < 8; l++) m_skip[l] = 0;
      return;
    end
    new_ped = m_ped || ped_req;
    case (m_phase)
      0: begin
        if (m_left > 1) m_left--;
        else if (emg_req) begin
          m_phase = 1; m_active = int'(emg_lane); m_elapsed = 1; m_emg = 1;
          m_skip[m_active] = 0;
        end else if (m_ped) begin
          m_phase = 3; m_left = WALK_T; new_ped = 0;
        end else begin
          pick = model_pick();
          if (pick >= 0) begin
            for (int l = 0; l < 8; l++)
              if (l != pick && lane_cnt(l) > 0 && m_skip[l] < 15) m_skip[l]++;
            m_skip[pick] = 0;
            m_phase = 1; m_active = pick; m_elapsed = 1;
          end
        end
      end
      1: begin
        if (emg_req) leave = (int'(emg_lane) != m_active);
        else if (m_emg) leave = (m_elapsed >= MIN_GREEN);
        else leave = (m_elapsed >= MIN_GREEN && lane_cnt(m_active) == 0) ||
                     (m_elapsed >= MAX_GREEN);
        if (leave) begin
          m_phase = 2; m_left = YELLOW_T; m_emg = 0;
        end else begin
          m_elapsed++;
          if (emg_req) m_emg = 1;
        end
      end
      2: begin
        if (m_left > 1) m_left--;
        else begin m_phase = 0; m_left = ALLRED_T; end
      end
      default: begin
        if (emg_req || m_left <= 1) begin m_phase = 0; m_left = ALLRED_T; end
        else m_left--;
      end
    endcase
    m_ped = new_ped;
  endtask

  // ---------------- helpers
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic [63:0] c, input logic p,
                       input logic e, input logic [2:0] el);
    rst = r; lane_counts = c; ped_req = p; emg_req = e; emg_lane = el;
  endtask

  task automatic check(input string nm, input logic [1:0] ep, input logic [7:0] eg,
                       input logic [7:0] ey, input logic ew, input logic [2:0] ea);
    n_cmp++;
    if (phase !== ep || green !== eg || yellow !== ey || walk !== ew || active_lane !== ea) begin
      n_fail++;
      $display("FAIL %s @%0t: got ph=%0d g=%h y=%h w=%0d act=%0d, want ph=%0d g=%h y=%h w=%0d act=%0d",
               nm, $time, phase, green, yellow, walk, active_lane, ep, eg, ey, ew, ea);
    end
  endtask

  function automatic logic [63:0] lanes(input int la, input int va, input int lb, input int vb);
    logic [63:0] c;
    c = '0;
    if (la >= 0) c[la*8 +: 8] = 8'(va);
    if (lb >= 0) c[lb*8 +: 8] = 8'(vb);
    return c;
  endfunction

  typedef struct {
    logic        rst;
    logic [63:0] counts;
    logic        ped;
    logic        emg;
    logic [2:0]  el;
    int          n;
    logic [1:0]  ph;
    logic [7:0]  g;
    logic [7:0]  y;
    logic        w;
    logic [2:0]  act;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [63:0] c, input logic p,
                              input logic e, input logic [2:0] el, input int n,
                              input logic [1:0] ph, input logic [7:0] g,
                              input logic [7:0] y, input logic w, input logic [2:0] act);
    vec_t v;
    v.rst = r; v.counts = c; v.ped = p; v.emg = e; v.el = el; v.n = n;
    v.ph = ph; v.g = g; v.y = y; v.w = w; v.act = act;
    return v;
  endfunction

  int emg_left;
  int grants [$];
  int prev_phase;

  initial begin
    drive(1'b1, '0, 1'b0, 1'b0, 3'd0);
    m_phase = 0; m_left = ALLRED_T; m_elapsed = 0; m_active = 7; m_ped = 0; m_emg = 0;
    for (int l = 0; l < 8; l++) m_skip[l] = 0;

    // rst, counts, ped, emg, emg_lane, cycles, phase, green, yellow, walk, active
    tbl.push_back(mk(1, '0,                 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(0, '0,                 0, 0, 0, 20, 0, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(0, lanes(2, 5, -1, 0), 0, 0, 0,  1, 1, 8'h04, 8'h00, 0, 2));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  4, 1, 8'h04, 8'h00, 0, 2));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  3, 2, 8'h00, 8'h04, 0, 2));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 2));
    tbl.push_back(mk(0, lanes(3, 9, -1, 0), 0, 0, 0, 30, 1, 8'h08, 8'h00, 0, 3));
    tbl.push_back(mk(0, lanes(3, 9, -1, 0), 0, 0, 0,  3, 2, 8'h00, 8'h08, 0, 3));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 3));
    tbl.push_back(mk(0, lanes(3, 9, -1, 0), 0, 0, 0,  2, 1, 8'h08, 8'h00, 0, 3));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  3, 1, 8'h08, 8'h00, 0, 3));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  3, 2, 8'h00, 8'h08, 0, 3));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 3));
    tbl.push_back(mk(0, lanes(1, 9, -1, 0), 0, 0, 0,  2, 1, 8'h02, 8'h00, 0, 1));
    tbl.push_back(mk(0, lanes(1, 9, -1, 0), 0, 1, 6,  3, 2, 8'h00, 8'h02, 0, 1));
    tbl.push_back(mk(0, lanes(1, 9, -1, 0), 0, 1, 6,  1, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(0, lanes(1, 9, -1, 0), 0, 1, 6, 10, 1, 8'h40, 8'h00, 0, 6));
    tbl.push_back(mk(0, lanes(1, 9, -1, 0), 0, 0, 0,  3, 2, 8'h00, 8'h40, 0, 6));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 6));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  2, 0, 8'h00, 8'h00, 0, 6));
    tbl.push_back(mk(0, lanes(0, 7, 4, 7),  0, 0, 0,  1, 1, 8'h01, 8'h00, 0, 0));
    tbl.push_back(mk(0, lanes(0, 7, 4, 7),  1, 0, 0,  1, 1, 8'h01, 8'h00, 0, 0));
    tbl.push_back(mk(0, lanes(4, 7, -1, 0), 0, 0, 0,  3, 1, 8'h01, 8'h00, 0, 0));
    tbl.push_back(mk(0, lanes(4, 7, -1, 0), 0, 0, 0,  3, 2, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(0, lanes(4, 7, -1, 0), 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, lanes(0, 7, 4, 7),  0, 0, 0, 10, 3, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, lanes(0, 7, 4, 7),  0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, lanes(0, 7, 4, 7),  0, 0, 0,  1, 1, 8'h10, 8'h00, 0, 4));
    tbl.push_back(mk(0, '0,                 1, 0, 0,  1, 1, 8'h10, 8'h00, 0, 4));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  3, 1, 8'h10, 8'h00, 0, 4));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  3, 2, 8'h00, 8'h10, 0, 4));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 4));
    tbl.push_back(mk(0, '0,                 0, 0, 0,  2, 3, 8'h00, 8'h00, 1, 4));
    tbl.push_back(mk(0, '0,                 0, 1, 2,  1, 0, 8'h00, 8'h00, 0, 4));
    tbl.push_back(mk(0, '0,                 0, 1, 2,  1, 1, 8'h04, 8'h00, 0, 2));
    tbl.push_back(mk(1, '0,                 0, 1, 2,  1, 0, 8'h00, 8'h00, 0, 7));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].counts, tbl[i].ped, tbl[i].emg, tbl[i].el);
      for (int j = 0; j < tbl[i].n; j++) begin
        step();
        check($sformatf("vec%0d.%0d", i, j), tbl[i].ph, tbl[i].g, tbl[i].y, tbl[i].w, tbl[i].act);
      end
    end

    // Emergency on the active lane holds green well past MAX_GREEN.
    drive(0, lanes(5, 9, -1, 0), 0, 0, 0);
    step(); check("emg_inplace_entry", 2'd1, 8'h20, 8'h00, 1'b0, 3'd5);
    drive(0, lanes(5, 9, -1, 0), 0, 1, 5);
    for (int j = 0; j < 40; j++) begin
      step(); check("emg_inplace_hold", 2'd1, 8'h20, 8'h00, 1'b0, 3'd5);
    end
    drive(0, lanes(5, 9, -1, 0), 0, 0, 0);
    step(); check("emg_inplace_release", 2'd2, 8'h00, 8'h20, 1'b0, 3'd5);

    // Held ped_req re-arms during WALK and yields a second walk.
    drive(1, '0, 0, 0, 0);
    step(); check("walk2_reset", 2'd0, 8'h00, 8'h00, 1'b0, 3'd7);
    drive(0, '0, 1, 0, 0);
    step(); check("walk2_arm", 2'd0, 8'h00, 8'h00, 1'b0, 3'd7);
    step(); check("walk2_first", 2'd3, 8'h00, 8'h00, 1'b1, 3'd7);
    step(); check("walk2_first", 2'd3, 8'h00, 8'h00, 1'b1, 3'd7);
    ped_req = 0;
    for (int j = 0; j < 8; j++) begin
      step(); check("walk2_first", 2'd3, 8'h00, 8'h00, 1'b1, 3'd7);
    end
    step(); check("walk2_gap", 2'd0, 8'h00, 8'h00, 1'b0, 3'd7);
    step(); check("walk2_second", 2'd3, 8'h00, 8'h00, 1'b1, 3'd7);

`ifdef SCHED_STARVE_GUARD_EN
    // Heavy lane 0 versus light lane 5: lane 5 wins on its 5th selection.
    drive(1, '0, 0, 0, 0);
    step();
    drive(0, lanes(0, 200, 5, 1), 0, 0, 0);
    prev_phase = 0;
    for (int j = 0; j < 400 && grants.size() < 5; j++) begin
      step();
      if (phase == 2'd1 && prev_phase != 1) grants.push_back(int'(active_lane));
      prev_phase = int'(phase);
    end
    n_cmp++;
    if (grants.size() < 5) begin
      n_fail++;
      $display("FAIL starve_timeout: got %0d grants, want 5", grants.size());
    end else if (grants[0] != 0 || grants[1] != 0 || grants[2] != 0 || grants[3] != 0 || grants[4] != 5) begin
      n_fail++;
      $display("FAIL starve_order: got %0d %0d %0d %0d %0d, want 0 0 0 0 5",
               grants[0], grants[1], grants[2], grants[3], grants[4]);
    end
`endif

    // Random stimulus against the reference model.
    drive(1, '0, 0, 0, 0);
    step();
    emg_left = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int l = 0; l < 8; l++) begin
          case ($urandom_range(0, 3))
            0, 3: lane_counts[l*8 +: 8] = 8'd0;
            1:    lane_counts[l*8 +: 8] = 8'($urandom_range(1, 3));
            default: lane_counts[l*8 +: 8] = 8'($urandom_range(0, 255));
          endcase
        end
      end
      ped_req = ($urandom_range(0, 39) == 0);
      if (emg_left > 0) begin
        emg_left--;
        if (emg_left == 0) emg_req = 0;
      end else if ($urandom_range(0, 149) == 0) begin
        emg_req  = 1;
        emg_lane = 3'($urandom_range(0, 7));
        emg_left = $urandom_range(3, 60);
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
      check($sformatf("rand%0d", cyc), 2'(m_phase),
            (m_phase == 1) ? 8'(1 << m_active) : 8'h00,
            (m_phase == 2) ? 8'(1 << m_active) : 8'h00,
            (m_phase == 3), 3'(m_active));
      n_cmp++;
      if ($countones({green, yellow, walk}) > 1) begin
        n_fail++;
        $display("FAIL onehot%0d: got g=%h y=%h w=%0d, want at most one lit", cyc, green, yellow, walk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_phase_scheduler.md
Name: lane_phase_scheduler

Overview:
- Day-mode phase sequencer for the 8-lane intersection.
- Picks which lane gets green from the per-lane queue counts and runs the GREEN -> YELLOW -> ALL_RED cycle with its own tick counters.
- Inserts a pedestrian WALK phase when requested and preempts for emergency vehicles.
- Its outputs drive the light-output mux in place of the stateless day-time selector.

Parameters:
- CNT_W, 8, width of each lane queue count
- MIN_GREEN, 5, minimum green ticks (non-emergency)
- MAX_GREEN, 30, maximum green ticks
- YELLOW_T, 3, yellow ticks
- ALLRED_T, 1, all-red clearance ticks
- WALK_T, 10, pedestrian walk ticks
- STARVE_LIMIT, 4, skipped selections before forced service (optional feature only)

Ports:
- clk, in, 1, 1 s tick clock
- rst, in, 1, synchronous active-high reset
- lane_counts, in, 8*CNT_W, packed queue counts; lane i at bits [i*CNT_W +: CNT_W]
- ped_req, in, 1, pedestrian button; level or pulse
- emg_req, in, 1, emergency request, held high while active
- emg_lane, in, 3, lane index the emergency vehicle is on
- green, out, 8, one-hot green lane, or zero
- yellow, out, 8, one-hot yellow lane, or zero
- walk, out, 1, pedestrian walk light
- phase, out, 2, 0=ALL_RED 1=GREEN 2=YELLOW 3=WALK
- active_lane, out, 3, lane currently or last served

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; no asynchronous reset anywhere.
- All outputs are registered and change only on the clk edge.
- Reset state:
  - phase=ALL_RED, green=0, yellow=0, walk=0, active_lane=7.
  - Phase timer loaded with ALLRED_T. ped_pending=0, emg_mode=0.
- rst high mid-phase returns to the reset state on the next edge, whatever state it was in.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the cycle the FSM enters WALK.
- Phase timer: counts down one per cycle. Each phase lasts exactly its load value in cycles.
- ALL_RED:
  - Shown for ALLRED_T cycles, then a next-state decision in priority order.
  - (1) emg_req=1: enter GREEN on emg_lane, emg_mode=1.
  - (2) ped_pending=1: enter WALK for WALK_T.
  - (3) Any lane count >0: enter GREEN on the selected lane.
  - (4) Otherwise stay in ALL_RED and re-evaluate every cycle (idle).
- Lane selection:
  - The lane with the largest count wins.
  - Ties go to the first lane in round-robin order starting at active_lane+1, wrapping mod 8.
  - active_lane updates on GREEN entry.
- GREEN (green[active_lane]=1):
  - Green elapsed counter starts at 1 on the first green cycle.
  - Non-emergency exit to YELLOW when either condition holds:
    - elapsed >= MIN_GREEN and the active lane's count == 0;
    - elapsed == MAX_GREEN.
  - Emergency mode: hold green while emg_req=1, with no MAX_GREEN cap. After emg_req drops, exit once elapsed >= MIN_GREEN. emg_mode clears on YELLOW entry.
  - emg_req=1 with emg_lane != active_lane: exit to YELLOW on the next edge, ignoring MIN_GREEN.
  - emg_req=1 with emg_lane == active_lane: converts to emergency mode in place.
- YELLOW: yellow[active_lane]=1, green=0 for YELLOW_T cycles, then ALL_RED. Not abortable.
- WALK:
  - walk=1, green=0, yellow=0 for WALK_T cycles, then ALL_RED.
  - emg_req=1 during WALK: go to ALL_RED on the next edge.
- Count width: compare counts unsigned, full CNT_W bits.
- Simultaneous events:
  - Emergency beats pedestrian; pedestrian beats traffic.
  - ped_req asserted during WALK after entry sets ped_pending again, giving a second walk.
- Invariant: at most one bit set across {green, yellow, walk} at any time.

Optional Feature:
- Macro SCHED_STARVE_GUARD_EN.
- Defined:
  - Each lane keeps a 4-bit skip counter.
  - It increments when the lane has count >0 at a selection and is not chosen.
  - It clears when the lane is granted green.
  - Any lane with skip >= STARVE_LIMIT wins selection over max-count. Among starved lanes, round-robin order applies.
  - Emergency and pedestrian priority are unchanged.
- Undefined: pure max-count plus round-robin selection; no skip counters are instantiated.

Test Plan:
- Reset, then all counts zero for 20 cycles -> phase=0 and green=0 throughout. Set lane 2 count=5 -> green=8'h04 after the current ALL_RED decision.
- Lane 3 count=9, others 0, count held -> green for exactly 30 cycles, yellow 8'h08 for 3, all-red for 1.
- Lane 3 served with count dropping to 0 at elapsed=2 -> green lasts 5 cycles (MIN_GREEN), then yellow.
- Lane 1 green at elapsed=2, emg_req=1 with emg_lane=6 -> yellow next cycle. Then 3 yellow, 1 all-red, then green=8'h40, held while emg_req=1.
- 1-cycle ped_req pulse during green, with lanes 0 and 4 both at count 7 -> after yellow and all-red: walk=1 for 10 cycles, then green on lane 4 (active_lane was 0, round-robin tie).
- With SCHED_STARVE_GUARD_EN: lane 0 count=200, lane 5 count=1 -> lane 5 granted at its 5th selection, after 4 skips.
